// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt controller.
//   - Register offsets relative to BASE_ADDR on the special-register bus.
//   - FSM state encoding, which software observes through the STATUS register.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQC_PENDING = 3'd0;
    localparam logic [2:0] IRQC_ENABLE  = 3'd1;
    localparam logic [2:0] IRQC_EDGE    = 3'd2;
    localparam logic [2:0] IRQC_CLAIM   = 3'd3;
    localparam logic [2:0] IRQC_EOI     = 3'd4;
    localparam logic [2:0] IRQC_STATUS  = 3'd5;

    localparam int unsigned IRQC_NUM_REGS = 6;

    // o_active_id value meaning "no source in service"
    localparam logic [3:0] IRQC_NO_ID = 4'hF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StService = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req    in  N_SRC  request vector (bit 0 = highest priority)
//   top_id out 4      index of the lowest set bit, 0 when req is all zero
//   any    out 1      OR of req
module irq_prio_enc #(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic [3:0]       top_id,
    output logic             any
);

    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        top_id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                top_id = 4'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller feeding the execute stage's single IRQ input.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_src            N_SRC interrupt lines, bit 0 highest priority
//   sr_bus_addr      special-register address
//   sr_bus_data_i    write data
//   sr_bus_we        write strobe
//   sr_bus_data_o    combinational read data, 0 outside BASE_ADDR..BASE_ADDR+5
//   o_irq            registered request to the execute stage
//   o_active_id      registered in-service source ID, 4'hF when none
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src,
    input  logic [15:0]      sr_bus_addr,
    input  logic [15:0]      sr_bus_data_i,
    input  logic             sr_bus_we,
    output logic [15:0]      sr_bus_data_o,
    output logic             o_irq,
    output logic [3:0]       o_active_id
);

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, edge_q, prev_q;
    irq_state_e       state_q, state_d;
    logic [3:0]       cur_id_q, cur_id_d;
    logic             irq_q, irq_d;
    logic [3:0]       active_id_q, active_id_d;

    // Address decode
    logic [15:0]      off;
    logic [2:0]       reg_sel;
    logic             in_range, wr;
    logic             pend_we, enable_we, edge_we, claim_we, eoi_we;
    logic [N_SRC-1:0] wdata;
    logic             unused_wdata;

    assign off       = sr_bus_addr - BASE_ADDR;
    assign in_range  = (sr_bus_addr >= BASE_ADDR) && (off < 16'(IRQC_NUM_REGS));
    assign reg_sel   = off[2:0];
    assign wr        = sr_bus_we && in_range;
    assign pend_we   = wr && (reg_sel == IRQC_PENDING);
    assign enable_we = wr && (reg_sel == IRQC_ENABLE);
    assign edge_we   = wr && (reg_sel == IRQC_EDGE);
    assign claim_we  = wr && (reg_sel == IRQC_CLAIM);
    assign eoi_we    = wr && (reg_sel == IRQC_EOI);
    assign wdata     = sr_bus_data_i[N_SRC-1:0];

    assign unused_wdata = ^sr_bus_data_i[15:N_SRC];

    // Request selection
    logic [N_SRC-1:0] req, cur_mask;
    logic [3:0]       top_id;
    logic             any, req_cur;

    assign req      = pending_q & enable_q;
    assign cur_mask = N_SRC'(1) << cur_id_q;
    assign req_cur  = |(req & cur_mask);

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req    (req),
        .top_id (top_id),
        .any    (any)
    );

    // Pending: edge bits set on a rising sample and clear by W1C or claim (set wins);
    // level bits simply track the registered line.
    logic [N_SRC-1:0] rise, clr;

    always_comb begin
        rise = i_src & ~prev_q;
        clr  = '0;
        if (pend_we) begin
            clr = clr | wdata;
        end
        if ((state_q == StAssert) && claim_we) begin
            clr = clr | cur_mask;
        end
        pending_d = (edge_q & (rise | (pending_q & ~clr))) | (~edge_q & i_src);
    end

    // FSM next state
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            StIdle: begin
                if (any) begin
                    cur_id_d = top_id;
                    state_d  = StAssert;
                end
            end
            StAssert: begin
                // cur_id stays fixed here: a higher-priority arrival never preempts
                if (claim_we) begin
                    state_d = StService;
                end else if (!req_cur) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi_we) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // o_irq lags entry into ASSERT by one cycle but drops on the same edge that leaves it,
    // so a claim or withdrawal is never followed by a stale request.
    always_comb begin
        irq_d       = (state_q == StAssert) && (state_d == StAssert);
        active_id_d = (state_d == StService) ? cur_id_d : IRQC_NO_ID;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q   <= '0;
            enable_q    <= '0;
            edge_q      <= '0;
            prev_q      <= '0;
            state_q     <= StIdle;
            cur_id_q    <= '0;
            irq_q       <= 1'b0;
            active_id_q <= IRQC_NO_ID;
        end else begin
            pending_q   <= pending_d;
            prev_q      <= i_src;
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            irq_q       <= irq_d;
            active_id_q <= active_id_d;
            if (enable_we) begin
                enable_q <= wdata;
            end
            if (edge_we) begin
                edge_q <= wdata;
            end
        end
    end

    // Read mux
    always_comb begin
        sr_bus_data_o = '0;
        if (in_range) begin
            case (reg_sel)
                IRQC_PENDING: sr_bus_data_o = 16'(pending_q);
                IRQC_ENABLE:  sr_bus_data_o = 16'(enable_q);
                IRQC_EDGE:    sr_bus_data_o = 16'(edge_q);
                IRQC_CLAIM:   sr_bus_data_o = {state_q == StAssert, 11'b0, cur_id_q};
                IRQC_STATUS:  sr_bus_data_o = {14'b0, state_q};
                default:      sr_bus_data_o = '0;
            endcase
        end
    end

    assign o_irq       = irq_q;
    assign o_active_id = active_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl with a scoreboard queue.
module tb_irq_ctrl;

    localparam logic [15:0] A_PEND   = 16'h0200;
    localparam logic [15:0] A_ENABLE = 16'h0201;
    localparam logic [15:0] A_EDGE   = 16'h0202;
    localparam logic [15:0] A_CLAIM  = 16'h0203;
    localparam logic [15:0] A_EOI    = 16'h0204;
    localparam logic [15:0] A_STATUS = 16'h0205;
    localparam logic [15:0] A_OOR    = 16'h0206;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_src;
    logic [15:0] sr_bus_addr, sr_bus_data_i, sr_bus_data_o;
    logic        sr_bus_we;
    logic        o_irq;
    logic [3:0]  o_active_id;

    irq_ctrl #(
        .N_SRC     (8),
        .BASE_ADDR (16'h0200)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_src         (i_src),
        .sr_bus_addr   (sr_bus_addr),
        .sr_bus_data_i (sr_bus_data_i),
        .sr_bus_we     (sr_bus_we),
        .sr_bus_data_o (sr_bus_data_o),
        .o_irq         (o_irq),
        .o_active_id   (o_active_id)
    );

    always #10 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h required=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        sr_bus_addr = a;
        #1;
        v = sr_bus_data_o;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        sr_bus_addr   = a;
        sr_bus_data_i = d;
        sr_bus_we     = 1'b1;
        step();
        sr_bus_we     = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        push(tag, exp);
        rd(a, v);
        pop_check(v);
    endtask

    task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    // Bounded wait for o_irq; an expired bound shows up as a failed comparison.
    task automatic wait_irq(input string tag);
        for (int k = 0; k < 12 && !o_irq; k++) begin
            step();
        end
        chk_val(tag, {15'b0, o_irq}, 16'h0001);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        i_rst = 1'b1;
        i_src = '0;
        sr_bus_addr = '0;
        sr_bus_data_i = '0;
        sr_bus_we = 1'b0;
        step();
        step();
        i_rst = 1'b0;

        // Reset state
        chk_val("rst_irq", {15'b0, o_irq}, 16'h0000);
        chk_val("rst_active", {12'b0, o_active_id}, 16'h000F);
        chk_reg("rst_pend", A_PEND, 16'h0000);
        chk_reg("rst_enable", A_ENABLE, 16'h0000);
        chk_reg("rst_edge", A_EDGE, 16'h0000);
        chk_reg("rst_status", A_STATUS, 16'h0000);
        chk_reg("rst_claim", A_CLAIM, 16'h0000);

        // Edge source 0: three-cycle latency, claim, EOI
        wr(A_ENABLE, 16'h0001);
        wr(A_EDGE, 16'h0001);
        i_src = 8'h01;
        push("lat_irq_t2", 16'h0000);
        push("lat_irq_t3", 16'h0001);
        step();
        i_src = 8'h00;
        step();
        pop_check({15'b0, o_irq});
        step();
        pop_check({15'b0, o_irq});
        chk_reg("t1_claim", A_CLAIM, 16'h8000);
        wr(A_CLAIM, 16'h0000);
        chk_val("t1_irq_after_claim", {15'b0, o_irq}, 16'h0000);
        chk_reg("t1_pend_after_claim", A_PEND, 16'h0000);
        chk_val("t1_active", {12'b0, o_active_id}, 16'h0000);
        chk_reg("t1_status_service", A_STATUS, 16'h0002);
        wr(A_EOI, 16'h0000);
        chk_reg("t1_status_eoi", A_STATUS, 16'h0000);
        chk_val("t1_active_eoi", {12'b0, o_active_id}, 16'h000F);

        // Level sources 2 and 3 together
        wr(A_EDGE, 16'h0000);
        wr(A_ENABLE, 16'h000C);
        i_src = 8'h0C;
        wait_irq("t2_irq_a");
        chk_reg("t2_claim_a", A_CLAIM, 16'h8002);
        wr(A_CLAIM, 16'h0000);
        chk_val("t2_active_a", {12'b0, o_active_id}, 16'h0002);
        wr(A_EOI, 16'h0000);
        wait_irq("t2_irq_b");
        chk_reg("t2_claim_b", A_CLAIM, 16'h8002);
        wr(A_CLAIM, 16'h0000);
        i_src = 8'h08;
        wr(A_EOI, 16'h0000);
        wait_irq("t2_irq_c");
        chk_reg("t2_claim_c", A_CLAIM, 16'h8003);
        wr(A_CLAIM, 16'h0000);
        chk_val("t2_active_c", {12'b0, o_active_id}, 16'h0003);
        i_src = 8'h00;
        wr(A_EOI, 16'h0000);
        wr(A_ENABLE, 16'h0000);
        chk_reg("t2_status_end", A_STATUS, 16'h0000);

        // Withdrawal by disabling
        wr(A_ENABLE, 16'h0020);
        i_src = 8'h20;
        wait_irq("t3_irq");
        wr(A_ENABLE, 16'h0000);
        step();
        chk_val("t3_irq_withdrawn", {15'b0, o_irq}, 16'h0000);
        chk_reg("t3_status", A_STATUS, 16'h0000);
        rd(A_CLAIM, v);
        chk_val("t3_claim_valid", {15'b0, v[15]}, 16'h0000);
        i_src = 8'h00;
        step();

        // Edge arrival during SERVICE is held pending, served after EOI
        wr(A_EDGE, 16'h0012);
        wr(A_ENABLE, 16'h0012);
        i_src = 8'h10;
        step();
        i_src = 8'h00;
        wait_irq("t4_irq_4");
        chk_reg("t4_claim_4", A_CLAIM, 16'h8004);
        wr(A_CLAIM, 16'h0000);
        i_src = 8'h02;
        step();
        i_src = 8'h00;
        step();
        step();
        chk_reg("t4_pend_in_service", A_PEND, 16'h0002);
        chk_val("t4_irq_in_service", {15'b0, o_irq}, 16'h0000);
        chk_val("t4_active_4", {12'b0, o_active_id}, 16'h0004);
        chk_reg("t4_status_service", A_STATUS, 16'h0002);
        wr(A_EOI, 16'h0000);
        wait_irq("t4_irq_1");
        chk_reg("t4_claim_1", A_CLAIM, 16'h8001);
        wr(A_CLAIM, 16'h0000);
        wr(A_EOI, 16'h0000);
        chk_reg("t4_pend_end", A_PEND, 16'h0000);

        // Simultaneous W1C and new edge: set wins
        wr(A_EDGE, 16'h0001);
        wr(A_ENABLE, 16'h0000);
        i_src = 8'h01;
        step();
        i_src = 8'h00;
        step();
        chk_reg("t5_pend_set", A_PEND, 16'h0001);
        i_src = 8'h01;
        wr(A_PEND, 16'h0001);
        chk_reg("t5_set_wins", A_PEND, 16'h0001);
        wr(A_PEND, 16'h0001);
        chk_reg("t5_w1c_alone", A_PEND, 16'h0000);
        i_src = 8'h00;
        step();

        // Out-of-range write, bits above N_SRC, CLAIM in IDLE
        wr(A_OOR, 16'hFFFF);
        chk_reg("t6_edge", A_EDGE, 16'h0001);
        chk_reg("t6_enable", A_ENABLE, 16'h0000);
        chk_reg("t6_pend", A_PEND, 16'h0000);
        chk_reg("t6_status", A_STATUS, 16'h0000);
        chk_reg("t6_oor_read", A_OOR, 16'h0000);
        chk_reg("t6_below_base", 16'h01FF, 16'h0000);
        wr(A_ENABLE, 16'hFF00);
        chk_reg("t6_enable_high_bits", A_ENABLE, 16'h0000);
        wr(A_CLAIM, 16'h0000);
        chk_reg("t6_claim_idle_status", A_STATUS, 16'h0000);
        chk_val("t6_claim_idle_active", {12'b0, o_active_id}, 16'h000F);
        chk_val("t6_claim_idle_irq", {15'b0, o_irq}, 16'h0000);

        // Reset during SERVICE
        wr(A_ENABLE, 16'h0001);
        i_src = 8'h01;
        step();
        i_src = 8'h00;
        wait_irq("t7_irq");
        wr(A_CLAIM, 16'h0000);
        chk_reg("t7_status_service", A_STATUS, 16'h0002);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk_val("t7_rst_irq", {15'b0, o_irq}, 16'h0000);
        chk_val("t7_rst_active", {12'b0, o_active_id}, 16'h000F);
        chk_reg("t7_rst_status", A_STATUS, 16'h0000);
        chk_reg("t7_rst_enable", A_ENABLE, 16'h0000);
        chk_reg("t7_rst_edge", A_EDGE, 16'h0000);
        chk_reg("t7_rst_claim", A_CLAIM, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
